// File: rtl/mux2to1.sv
// -----------------------------------------------------------------------------
// mux2to1
//   Parameterised 2:1 data multiplexer. Provides a purely combinational
//   result, a registered copy of that result, and select-line activity
//   monitoring for debug.
//
// Parameters
//   WIDTH      data width of in1, in2, out and out_reg
//   CNT_W      width of the saturating select-change counter (1..32)
//
// Ports
//   sys_clk    system clock, rising edge
//   sys_rst_n  asynchronous active-low reset
//   in1        data source A, selected when sel=1
//   in2        data source B, selected when sel=0
//   sel        select line (assumed synchronous to sys_clk)
//   clr_cnt    synchronous clear of sel_cnt, active high
//   out        combinational mux result
//   out_reg    out registered on sys_clk (1-cycle latency)
//   sel_chg    one-cycle pulse when sampled sel differs from previous sample
//   sel_cnt    saturating count of detected sel changes
// -----------------------------------------------------------------------------
module mux2to1 #(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned CNT_W = 8
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             sel,
   input  logic             clr_cnt,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] out_reg,
   output logic             sel_chg,
   output logic [CNT_W-1:0] sel_cnt
);

   logic sel_d;    // sel sampled on the previous edge
   logic primed;   // set once sel_d holds a real sample rather than its reset value
   logic chg;      // change condition seen at the upcoming edge
   logic cnt_full; // counter at its saturation value

   // Combinational path: independent of clock and reset.
   assign out = sel ? in1 : in2;

   // Without primed, the reset value of sel_d would fake a change on the
   // first edge whenever sel=1 at reset release.
   assign chg      = primed & (sel ^ sel_d);
   assign cnt_full = &sel_cnt;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         out_reg <= '0;
         sel_d   <= 1'b0;
         primed  <= 1'b0;
         sel_chg <= 1'b0;
         sel_cnt <= '0;
      end else begin
         out_reg <= out;
         sel_d   <= sel;
         primed  <= 1'b1;
         sel_chg <= chg;
         // Clear wins over increment; the pulse on sel_chg is unaffected.
         if (clr_cnt) begin
            sel_cnt <= '0;
         end else if (chg && !cnt_full) begin
            sel_cnt <= sel_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mux2to1.sv
// -----------------------------------------------------------------------------
// tb_mux2to1
//   Self-checking bench for mux2to1. Two instances share clock and reset:
//   u_w8 (WIDTH=8, CNT_W=8) for the byte datapath and change counting,
//   u_b1 (WIDTH=1, CNT_W=2) for the bit-level combinational sequence and
//   counter saturation. Expected registered outputs are computed from a
//   bench-side model when inputs are driven, queued, and compared after
//   the clock edge.
// -----------------------------------------------------------------------------
module tb_mux2to1;

   logic       clk;
   logic       rst_n;

   logic [7:0] in1_8, in2_8;
   logic       sel_8, clr_8;
   logic [7:0] out_8, oreg_8;
   logic       chg_8;
   logic [7:0] cnt_8;

   logic       in1_b, in2_b;
   logic       sel_b, clr_b;
   logic       out_b, oreg_b;
   logic       chg_b;
   logic [1:0] cnt_b;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [7:0] oreg8;
      logic       chg8;
      logic [7:0] cnt8;
      logic       oregb;
      logic       chgb;
      logic [1:0] cntb;
   } exp_t;

   exp_t sb[$];

   // reference model state
   logic       m8_seld, m8_primed;
   logic [7:0] m8_cnt;
   logic       mb_seld, mb_primed;
   logic [1:0] mb_cnt;

   mux2to1 #(.WIDTH(8), .CNT_W(8)) u_w8 (
      .sys_clk   (clk),
      .sys_rst_n (rst_n),
      .in1       (in1_8),
      .in2       (in2_8),
      .sel       (sel_8),
      .clr_cnt   (clr_8),
      .out       (out_8),
      .out_reg   (oreg_8),
      .sel_chg   (chg_8),
      .sel_cnt   (cnt_8)
   );

   mux2to1 #(.WIDTH(1), .CNT_W(2)) u_b1 (
      .sys_clk   (clk),
      .sys_rst_n (rst_n),
      .in1       (in1_b),
      .in2       (in2_b),
      .sel       (sel_b),
      .clr_cnt   (clr_b),
      .out       (out_b),
      .out_reg   (oreg_b),
      .sel_chg   (chg_b),
      .sel_cnt   (cnt_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m8_seld = 1'b0; m8_primed = 1'b0; m8_cnt = '0;
      mb_seld = 1'b0; mb_primed = 1'b0; mb_cnt = '0;
   endtask

   // Compute expectations from current inputs, queue them, clock once, compare.
   task automatic step(input string tag);
      exp_t e;
      e.oreg8 = sel_8 ? in1_8 : in2_8;
      e.chg8  = m8_primed && (sel_8 != m8_seld);
      if (clr_8)                          m8_cnt = '0;
      else if (e.chg8 && m8_cnt != 8'hFF) m8_cnt = m8_cnt + 8'd1;
      e.cnt8    = m8_cnt;
      m8_seld   = sel_8;
      m8_primed = 1'b1;

      e.oregb = sel_b ? in1_b : in2_b;
      e.chgb  = mb_primed && (sel_b != mb_seld);
      if (clr_b)                         mb_cnt = '0;
      else if (e.chgb && mb_cnt != 2'd3) mb_cnt = mb_cnt + 2'd1;
      e.cntb    = mb_cnt;
      mb_seld   = sel_b;
      mb_primed = 1'b1;
      sb.push_back(e);

      @(posedge clk);
      #1;
      e = sb.pop_front();
      check({tag, ":oreg8"}, 32'(oreg_8), 32'(e.oreg8));
      check({tag, ":chg8"},  32'(chg_8),  32'(e.chg8));
      check({tag, ":cnt8"},  32'(cnt_8),  32'(e.cnt8));
      check({tag, ":oregb"}, 32'(oreg_b), 32'(e.oregb));
      check({tag, ":chgb"},  32'(chg_b),  32'(e.chgb));
      check({tag, ":cntb"},  32'(cnt_b),  32'(e.cntb));
      check({tag, ":out8"},  32'(out_8),  32'(sel_8 ? in1_8 : in2_8));
   endtask

   // absolute change times for the bit-level combinational sequence
   int         ct  [7] = '{15, 20, 30, 60, 70, 80, 90};
   logic [2:0] cv  [7] = '{3'b011, 3'b010, 3'b000, 3'b111, 3'b101, 3'b100, 3'b000}; // {in1,in2,sel}
   logic       cexp[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

   initial begin
      rst_n = 1'b0;
      in1_b = 1'b1; in2_b = 1'b1; sel_b = 1'b1; clr_b = 1'b0;
      in1_8 = 8'h00; in2_8 = 8'h00; sel_8 = 1'b0; clr_8 = 1'b0;
      model_reset();

      // combinational path, exercised while reset is held
      #1;
      check("comb_t0", 32'(out_b), 32'(1'b1));
      for (int i = 0; i < 7; i++) begin
         #(ct[i] - int'($time));
         {in1_b, in2_b, sel_b} = cv[i];
         #1;
         check($sformatf("comb_t%0d", ct[i]), 32'(out_b), 32'(cexp[i]));
      end

      // reset state of both instances
      check("rst_oreg8", 32'(oreg_8), 32'(0));
      check("rst_chg8",  32'(chg_8),  32'(0));
      check("rst_cnt8",  32'(cnt_8),  32'(0));
      check("rst_oregb", 32'(oreg_b), 32'(0));
      check("rst_cntb",  32'(cnt_b),  32'(0));

      // release with sel=1: no change pulse on the first edge
      @(negedge clk);
      in1_8 = 8'hA5; in2_8 = 8'h3C; sel_8 = 1'b1;
      in1_b = 1'b1;  in2_b = 1'b0;  sel_b = 1'b1;
      rst_n = 1'b1;
      step("first");
      check("first_nochg8", 32'(chg_8), 32'(0));
      check("first_oregA5", 32'(oreg_8), 32'(8'hA5));

      // switch to in2: out immediately, out_reg after the edge
      sel_8 = 1'b0;
      #1;
      check("sw_out3C", 32'(out_8), 32'(8'h3C));
      check("sw_oreg_hold", 32'(oreg_8), 32'(8'hA5));
      step("sw");
      check("sw_oreg3C", 32'(oreg_8), 32'(8'h3C));
      step("sw_idle");
      check("pulse_1cyc", 32'(chg_8), 32'(0));

      // two more toggles on u_w8, five on u_b1, one toggle per two cycles
      for (int i = 0; i < 5; i++) begin
         if (i < 2) sel_8 = ~sel_8;
         sel_b = ~sel_b;
         step("tog");
         step("tog_idle");
      end
      check("cnt8_three", 32'(cnt_8), 32'(3));
      check("cntb_sat",   32'(cnt_b), 32'(3));

      // clear together with a toggle: counter zero, pulse still present
      sel_b = ~sel_b; clr_b = 1'b1;
      step("clr");
      check("clr_cnt0", 32'(cnt_b), 32'(0));
      check("clr_chg1", 32'(chg_b), 32'(1));
      clr_b = 1'b0;

      // back-to-back changes give back-to-back pulses
      sel_8 = ~sel_8; step("b2b0");
      sel_8 = ~sel_8; step("b2b1");
      check("b2b_chg", 32'(chg_8), 32'(1));

      // mixed random traffic
      for (int i = 0; i < 40; i++) begin
         in1_8 = 8'($urandom); in2_8 = 8'($urandom);
         sel_8 = 1'($urandom); clr_8 = ($urandom_range(0, 7) == 0);
         in1_b = 1'($urandom); in2_b = 1'($urandom);
         sel_b = 1'($urandom); clr_b = ($urandom_range(0, 7) == 0);
         step("rnd");
      end
      clr_8 = 1'b0; clr_b = 1'b0;

      // async reset mid-run, between edges
      sel_8 = ~sel_8; sel_b = ~sel_b;
      step("pre_rst");
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("arst_oreg8", 32'(oreg_8), 32'(0));
      check("arst_chg8",  32'(chg_8),  32'(0));
      check("arst_cnt8",  32'(cnt_8),  32'(0));
      check("arst_chgb",  32'(chg_b),  32'(0));
      check("arst_cntb",  32'(cnt_b),  32'(0));
      in1_8 = 8'h5A; in2_8 = 8'hC3; sel_8 = 1'b1;
      sel_b = 1'b1;
      #1;
      check("arst_out8", 32'(out_8), 32'(8'h5A));
      sel_8 = 1'b0;
      #1;
      check("arst_out8b", 32'(out_8), 32'(8'hC3));
      sel_8 = 1'b1;
      @(posedge clk);
      #1;
      check("arst_hold", 32'(oreg_8), 32'(0));
      #2;
      rst_n = 1'b1;
      step("rel");
      check("rel_nochg8", 32'(chg_8), 32'(0));
      check("rel_nochgb", 32'(chg_b), 32'(0));
      sel_8 = 1'b0;
      step("rel_tog");

      check("sb_empty", 32'(sb.size()), 32'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
